vx_mem_tag_remap: RTL
=====================

Name: vx_mem_tag_remap

Overview:
- Sits directly downstream of one Vortex top-level memory port, between it and the platform memory controller.
- Compresses the wide Vortex memory tag into a small outstanding-request ID, so platforms with narrow tag or ID fields (AXI ID, Avalon) can attach.
- Stores the original tag in an internal table and restores it on the read response.
- Instantiated once per `VX_MEM_PORTS` lane.

Parameters:
- ADDR_WIDTH, 26: memory line-address width (`VX_MEM_ADDR_WIDTH`).
- DATA_WIDTH, 512: line data width (`VX_MEM_DATA_WIDTH`).
- TAG_IN_WIDTH, 16: upstream tag width (`VX_MEM_TAG_WIDTH`).
- TAG_OUT_WIDTH, 4: downstream tag width. Table depth is NUM_IDS = 2^TAG_OUT_WIDTH.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- in_req_valid/in_req_rw, in, 1 each: upstream request valid / write flag.
- in_req_byteen, in, DATA_WIDTH/8: upstream byte enables.
- in_req_addr, in, ADDR_WIDTH: upstream address.
- in_req_data, in, DATA_WIDTH: upstream write data.
- in_req_tag, in, TAG_IN_WIDTH: upstream tag.
- in_req_ready, out, 1: upstream request accept.
- in_rsp_valid, out, 1: upstream response valid.
- in_rsp_data, out, DATA_WIDTH: upstream response data.
- in_rsp_tag, out, TAG_IN_WIDTH: restored original tag.
- in_rsp_ready, in, 1: upstream response accept.
- out_req_valid/out_req_rw, out, 1 each: downstream request valid / write flag.
- out_req_byteen, out, DATA_WIDTH/8: downstream byte enables.
- out_req_addr, out, ADDR_WIDTH: downstream address.
- out_req_data, out, DATA_WIDTH: downstream write data.
- out_req_tag, out, TAG_OUT_WIDTH: downstream ID.
- out_req_ready, in, 1: downstream request accept.
- out_rsp_valid, in, 1: downstream response valid.
- out_rsp_data, in, DATA_WIDTH: downstream response data.
- out_rsp_tag, in, TAG_OUT_WIDTH: downstream response ID.
- out_rsp_ready, out, 1: downstream response accept.
- pending, out, TAG_OUT_WIDTH+1: number of outstanding reads.
- idle, out, 1: high when pending == 0.

Behaviour:
- State:
  - free mask: NUM_IDS bits, 1 = free.
  - tag table: NUM_IDS x TAG_IN_WIDTH.
  - pending counter.
- Reset (synchronous):
  - free mask = all ones, pending = 0, idle = 1.
  - Table contents don't-care.
  - Since valids are combinational from their inputs, out_req_valid and in_rsp_valid are 0 whenever their source valids are 0.
- Request path is zero-latency combinational.
  - Payload (rw, byteen, addr, data) passes through unchanged.
- Read request (rw=0):
  - alloc_id = lowest-index set bit of the free mask.
  - out_req_valid = in_req_valid & any_free.
  - in_req_ready = out_req_ready & any_free.
  - out_req_tag = alloc_id.
  - On fire: table[alloc_id] <= in_req_tag, free[alloc_id] <= 0.
- Write request (rw=1):
  - Writes generate no response, so no allocation.
  - out_req_tag = 0; out_req_valid = in_req_valid; in_req_ready = out_req_ready.
  - Writes proceed even when all IDs are in use.
- Full (no free ID): reads stall with in_req_ready=0 and out_req_valid=0. Writes are unaffected.
- Response path is zero-latency combinational:
  - in_rsp_valid = out_rsp_valid.
  - in_rsp_data = out_rsp_data.
  - in_rsp_tag = table[out_rsp_tag].
  - out_rsp_ready = in_rsp_ready.
  - On fire: free[out_rsp_tag] <= 1.
- Simultaneous read fire and response fire in one cycle:
  - Both updates apply.
  - pending is unchanged.
  - An ID freed this cycle becomes allocatable the next cycle only; the allocator sees registered free mask state.
  - Read fire with no response: pending +1. Response with no read fire: pending −1.
- Responses may return in any order. IDs are reused only after their response fires.
- Reset mid-operation: all IDs are freed immediately. Responses to pre-reset requests are the environment's responsibility to drop; the block gives no guarantee on them.
- Simulation assertions (`ASSERT`):
  - response fire on an ID that is already free is an error;
  - pending never exceeds NUM_IDS.

Optional Feature:
- Macro: MEM_TAG_REMAP_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles (`PERF_CTR_BITS`) and perf_peak_pending (TAG_OUT_WIDTH+1).
  - perf_stall_cycles counts cycles with in_req_valid & ~in_req_rw & ~any_free.
  - perf_peak_pending holds the maximum pending value seen.
  - Both reset to 0.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- VX_gpu_pkg: add localparam MEM_REMAP_TAG_OUT_WIDTH = 4.
- Sub-module vx_tag_free_list holds the free mask, priority-encoded allocation (alloc_valid, alloc_id, alloc_fire), release port (release_fire, release_id) and the pending counter.
- Top-level vx_mem_tag_remap holds the tag table and the handshake glue.

Test Plan:
- Single read: tag 0x1234 -> out_req_tag=0. Response on ID 0 -> in_rsp_tag=0x1234, pending returns 0, idle=1.
- Fill (TAG_OUT_WIDTH=2): 4 reads with tags 0xA..0xD get IDs 0..3. 5th read -> in_req_ready=0 while out_req_ready=1. A write issued at the same time fires with out_req_tag=0.
- Out-of-order return: responses on IDs 2,0,3,1 -> tags 0xC,0xA,0xD,0xB. Next read allocates ID 0.
- Same-cycle free/alloc at full: response on ID 1 fires while a read is waiting. The read stalls that cycle, then fires next cycle with ID 1; pending goes 4 -> 3 -> 4.
- Backpressure: in_rsp_ready=0 for 5 cycles -> out_rsp_ready=0 and the ID stays allocated. Release happens on the cycle in_rsp_ready rises.
- Reset with 3 outstanding reads -> next cycle pending=0, idle=1, free mask all ones. First read after reset gets ID 0.

Source files
------------

// File: rtl/vx_mem_tag_remap_pkg.sv
// ============================================================================
//  Module   : vx_mem_tag_remap_pkg
//  Purpose  : Shared constants for the memory tag remapper slice.
//  Contents : MEM_REMAP_TAG_OUT_WIDTH - default downstream ID width
//             PERF_CTR_BITS           - width of the optional perf counters
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vx_mem_tag_remap_pkg;

    localparam int MEM_REMAP_TAG_OUT_WIDTH = 4;
    localparam int PERF_CTR_BITS           = 44;

endpackage

`default_nettype wire

// File: rtl/vx_tag_free_list.sv
// ============================================================================
//  Module   : vx_tag_free_list
//  Purpose  : Pool of NUM_IDS = 2^ID_WIDTH outstanding-request IDs. Hands out
//             the lowest free ID, takes IDs back on release, and tracks how
//             many are in use.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             alloc_valid/alloc_id - an ID is free / lowest free ID
//             alloc_fire          - consume alloc_id this cycle
//             release_fire/id     - return an ID to the pool this cycle
//             pending, idle       - IDs in use / no IDs in use
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_tag_free_list #(
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic                alloc_valid,
    output logic [ID_WIDTH-1:0] alloc_id,
    input  logic                alloc_fire,
    input  logic                release_fire,
    input  logic [ID_WIDTH-1:0] release_id,
    output logic [ID_WIDTH:0]   pending,
    output logic                idle
);

    localparam int NUM_IDS = 2 ** ID_WIDTH;
    localparam logic [ID_WIDTH:0] c_one         = (ID_WIDTH + 1)'(1);
    localparam logic [ID_WIDTH:0] c_max_pending = (ID_WIDTH + 1)'(NUM_IDS);

    logic [NUM_IDS-1:0]  r_free_mask;
    logic [ID_WIDTH:0]   r_pending;
    logic [ID_WIDTH-1:0] w_alloc_id;
    logic [NUM_IDS-1:0]  w_alloc_mask;
    logic [NUM_IDS-1:0]  w_release_mask;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        w_alloc_id = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (r_free_mask[i]) begin
                w_alloc_id = ID_WIDTH'(i);
            end
        end
    end

    assign w_alloc_mask   = NUM_IDS'(alloc_fire)   << w_alloc_id;
    assign w_release_mask = NUM_IDS'(release_fire) << release_id;

    assign alloc_valid = |r_free_mask;
    assign alloc_id    = w_alloc_id;
    assign pending     = r_pending;
    assign idle        = (r_pending == '0);

    // An ID released this cycle is only visible to the allocator next cycle,
    // since allocation always reads the registered mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_free_mask <= '1;
            r_pending   <= '0;
        end else begin
            r_free_mask <= (r_free_mask & ~w_alloc_mask) | w_release_mask;
            case ({alloc_fire, release_fire})
                2'b10:   r_pending <= r_pending + c_one;
                2'b01:   r_pending <= r_pending - c_one;
                default: r_pending <= r_pending;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(release_fire && r_free_mask[release_id]));
            assert (r_pending <= c_max_pending);
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/vx_mem_tag_remap.sv
// ============================================================================
//  Module   : vx_mem_tag_remap
//  Purpose  : Compresses the wide upstream memory tag into a small
//             outstanding-read ID for narrow-ID memory controllers, and
//             restores the original tag on the read response.
//  Ports    : clk, reset              - clock, synchronous active-high reset
//             in_req_*  / in_rsp_*    - upstream (core side) request/response
//             out_req_* / out_rsp_*   - downstream (controller) request/response
//             pending, idle           - outstanding reads / none outstanding
//             perf_stall_cycles       - (MEM_TAG_REMAP_PERF_EN) read-stall cycles
//             perf_peak_pending       - (MEM_TAG_REMAP_PERF_EN) peak pending
//  Options  : define MEM_TAG_REMAP_PERF_EN to add the performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_mem_tag_remap
    import vx_mem_tag_remap_pkg::*;
#(
    parameter int ADDR_WIDTH    = 26,
    parameter int DATA_WIDTH    = 512,
    parameter int TAG_IN_WIDTH  = 16,
    parameter int TAG_OUT_WIDTH = MEM_REMAP_TAG_OUT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      in_req_valid,
    input  logic                      in_req_rw,
    input  logic [DATA_WIDTH/8-1:0]   in_req_byteen,
    input  logic [ADDR_WIDTH-1:0]     in_req_addr,
    input  logic [DATA_WIDTH-1:0]     in_req_data,
    input  logic [TAG_IN_WIDTH-1:0]   in_req_tag,
    output logic                      in_req_ready,

    output logic                      in_rsp_valid,
    output logic [DATA_WIDTH-1:0]     in_rsp_data,
    output logic [TAG_IN_WIDTH-1:0]   in_rsp_tag,
    input  logic                      in_rsp_ready,

    output logic                      out_req_valid,
    output logic                      out_req_rw,
    output logic [DATA_WIDTH/8-1:0]   out_req_byteen,
    output logic [ADDR_WIDTH-1:0]     out_req_addr,
    output logic [DATA_WIDTH-1:0]     out_req_data,
    output logic [TAG_OUT_WIDTH-1:0]  out_req_tag,
    input  logic                      out_req_ready,

    input  logic                      out_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     out_rsp_data,
    input  logic [TAG_OUT_WIDTH-1:0]  out_rsp_tag,
    output logic                      out_rsp_ready,

`ifdef MEM_TAG_REMAP_PERF_EN
    output logic [PERF_CTR_BITS-1:0]  perf_stall_cycles,
    output logic [TAG_OUT_WIDTH:0]    perf_peak_pending,
`endif
    output logic [TAG_OUT_WIDTH:0]    pending,
    output logic                      idle
);

    localparam int NUM_IDS = 2 ** TAG_OUT_WIDTH;

    logic                     w_any_free;
    logic [TAG_OUT_WIDTH-1:0] w_alloc_id;
    logic                     w_alloc_fire;
    logic                     w_release_fire;
    logic                     w_req_go;
    logic [TAG_OUT_WIDTH:0]   w_pending;

    logic [TAG_IN_WIDTH-1:0]  r_tag_table [NUM_IDS];

    // Writes never produce a response, so they bypass ID allocation entirely
    // and keep flowing even when every ID is in use.
    assign w_req_go = in_req_rw | w_any_free;

    assign out_req_valid  = in_req_valid & w_req_go;
    assign in_req_ready   = out_req_ready & w_req_go;
    assign out_req_rw     = in_req_rw;
    assign out_req_byteen = in_req_byteen;
    assign out_req_addr   = in_req_addr;
    assign out_req_data   = in_req_data;
    assign out_req_tag    = in_req_rw ? '0 : w_alloc_id;

    assign w_alloc_fire   = in_req_valid & ~in_req_rw & out_req_ready & w_any_free;

    assign in_rsp_valid   = out_rsp_valid;
    assign in_rsp_data    = out_rsp_data;
    assign in_rsp_tag     = r_tag_table[out_rsp_tag];
    assign out_rsp_ready  = in_rsp_ready;

    assign w_release_fire = out_rsp_valid & in_rsp_ready;

    // Table contents are don't-care after reset; an entry is only read back
    // for an ID that was written when it was allocated.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_tag_table[w_alloc_id] <= in_req_tag;
        end
    end

    vx_tag_free_list #(
        .ID_WIDTH (TAG_OUT_WIDTH)
    ) u_free_list (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (w_any_free),
        .alloc_id     (w_alloc_id),
        .alloc_fire   (w_alloc_fire),
        .release_fire (w_release_fire),
        .release_id   (out_rsp_tag),
        .pending      (w_pending),
        .idle         (idle)
    );

    assign pending = w_pending;

`ifdef MEM_TAG_REMAP_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_perf_stall_cycles;
    logic [TAG_OUT_WIDTH:0]   r_perf_peak_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall_cycles <= '0;
            r_perf_peak_pending <= '0;
        end else begin
            if (in_req_valid && !in_req_rw && !w_any_free) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + PERF_CTR_BITS'(1);
            end
            if (w_pending > r_perf_peak_pending) begin
                r_perf_peak_pending <= w_pending;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_peak_pending = r_perf_peak_pending;
`endif

endmodule

`default_nettype wire
